// File: rtl/timer_pkg.sv
// Shared definitions for the timer control stage: register word offsets,
// CTRL/STATUS bit positions and the sequencing FSM state encoding.
package timer_pkg;

    localparam int unsigned REG_LOAD   = 0;
    localparam int unsigned REG_CTRL   = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_COUNT  = 3;
    localparam int unsigned REG_EXPCNT = 4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_STOP   = 3;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GUARD = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/timer_ctrl.sv
// Memory-mapped control stage in front of the countdown timer: load value,
// start pulse, sticky done/error status and interrupt.
// Optional expiry counter at word 4 when TIMER_CTRL_EXPCNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a START write
// ARM   | tmr_st high for this one cycle
// GUARD | timer reloads and clears td; td not yet trustworthy
// RUN   | waiting for tmr_td, then reload (AUTO) or return to IDLE
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic [DW-1:0] tmr_k,
    output logic          tmr_st,
    input  logic [DW-1:0] tmr_q,
    input  logic          tmr_td,
    output logic          irq
);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] load_q;
    logic          auto_q;
    logic          irq_en_q;
    logic          done_q;
    logic          err_q;
    logic          busy;
    logic          done_set;
    logic          err_set;

    logic wr_load;
    logic wr_ctrl;
    logic wr_status;
    logic start_go;
    logic stop_wr;

    assign wr_load   = we && (addr == AW'(REG_LOAD));
    assign wr_ctrl   = we && (addr == AW'(REG_CTRL));
    assign wr_status = we && (addr == AW'(REG_STATUS));
    // STOP beats START when both bits land in the same write
    assign stop_wr   = wr_ctrl && wd[CTRL_STOP];
    assign start_go  = wr_ctrl && wd[CTRL_START] && !wd[CTRL_STOP];

    assign tmr_k = load_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_go && (load_q != '0)) begin
                    state_nxt = ARM;
                end
            end
            ARM:   state_nxt = stop_wr ? IDLE : GUARD;
            GUARD: state_nxt = stop_wr ? IDLE : RUN;
            RUN: begin
                if (stop_wr) begin
                    state_nxt = IDLE;
                end else if (tmr_td) begin
                    state_nxt = auto_q ? ARM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tmr_st   = (state == ARM);
        busy     = (state != IDLE);
        done_set = (state == RUN) && tmr_td && !stop_wr;
        err_set  = (state == IDLE) && start_go && (load_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q   <= '0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_load) begin
                load_q <= wd;
            end
            if (wr_ctrl) begin
                auto_q   <= wd[CTRL_AUTO];
                irq_en_q <= wd[CTRL_IRQ_EN];
            end
            // a fresh expiry outranks a simultaneous write-1-clear
            if (done_set) begin
                done_q <= 1'b1;
            end else if (wr_status && wd[STAT_DONE]) begin
                done_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (wr_status && wd[STAT_ERR]) begin
                err_q <= 1'b0;
            end
            irq <= done_q && irq_en_q;
        end
    end

`ifdef TIMER_CTRL_EXPCNT_EN
    logic [DW-1:0] expcnt_q;
    logic          wr_expcnt;

    assign wr_expcnt = we && (addr == AW'(REG_EXPCNT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            expcnt_q <= '0;
        end else if (wr_expcnt) begin
            expcnt_q <= '0;
        end else if (done_set) begin
            expcnt_q <= expcnt_q + DW'(1);
        end
    end
`endif

    always_comb begin
        rd = '0;
        case (addr)
            AW'(REG_LOAD):   rd = load_q;
            AW'(REG_CTRL): begin
                rd[CTRL_AUTO]   = auto_q;
                rd[CTRL_IRQ_EN] = irq_en_q;
            end
            AW'(REG_STATUS): begin
                rd[STAT_DONE] = done_q;
                rd[STAT_BUSY] = busy;
                rd[STAT_ERR]  = err_q;
            end
            AW'(REG_COUNT):  rd = tmr_q;
`ifdef TIMER_CTRL_EXPCNT_EN
            AW'(REG_EXPCNT): rd = expcnt_q;
`endif
            default:         rd = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl with a simple behavioural
// countdown timer (reload on st rising edge, td = q==0).
module tb_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] tmr_k;
    logic        tmr_st;
    logic [31:0] tmr_q;
    logic        tmr_td;
    logic        irq;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int st_times[$];

    logic [31:0] tq   = '0;
    logic        st_d = 1'b0;

    timer_ctrl #(.DW(32), .AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .we     (we),
        .wd     (wd),
        .rd     (rd),
        .tmr_k  (tmr_k),
        .tmr_st (tmr_st),
        .tmr_q  (tmr_q),
        .tmr_td (tmr_td),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        st_d <= tmr_st;
        if (tmr_st && !st_d) tq <= tmr_k;
        else if (tq != 0)    tq <= tq - 1;
    end
    assign tmr_q  = tq;
    assign tmr_td = (tq == 0);

    always @(negedge clk) if (tmr_st) st_times.push_back(cyc);

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wd = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wd = '0;
    endtask

    task automatic rdw(input logic [2:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        #1;
        while (st_times.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk_cnt++;
        if (st_times.size() < n) $display("FAIL pulse_wait: got %0d pulses need %0d", st_times.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        for (int i = 0; i < 5; i++) begin
            rdw(i[2:0], v);
            chk_cnt++;
            if (v !== 32'h0) $display("FAIL reset_word%0d: got %0h exp 0", i, v);
            else pass_cnt++;
        end
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq); else pass_cnt++;
        chk_cnt++;
        if (tmr_st !== 1'b0) $display("FAIL reset_st: got %b exp 0", tmr_st); else pass_cnt++;
        chk_cnt++;
        if (tmr_k !== 32'h0) $display("FAIL reset_k: got %0h exp 0", tmr_k); else pass_cnt++;
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        int n;
        int s0;
        wr(3'd0, 32'd5);
        s0 = st_times.size();
        wr(3'd1, 32'h5);
        #1;
        chk_cnt++;
        if (tmr_st !== 1'b1) $display("FAIL os_st_arm: got %b exp 1", tmr_st); else pass_cnt++;
        chk_cnt++;
        if (tmr_k !== 32'd5) $display("FAIL os_k: got %0h exp 5", tmr_k); else pass_cnt++;
        rdw(3'd2, v);
        chk_cnt++;
        if (v[1] !== 1'b1) $display("FAIL os_busy: got %b exp 1", v[1]); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if (tmr_st !== 1'b0) $display("FAIL os_st_guard: got %b exp 0", tmr_st); else pass_cnt++;
        n = 1;
        rdw(3'd2, v);
        while (!v[0] && n < 30) begin
            @(negedge clk); n++; rdw(3'd2, v);
        end
        chk_cnt++;
        if (n !== 7) $display("FAIL os_done_latency: got %0d exp 7", n); else pass_cnt++;
        chk_cnt++;
        if (v !== 32'h1) $display("FAIL os_status_done: got %0h exp 1", v); else pass_cnt++;
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL os_irq_early: got %b exp 0", irq); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL os_irq: got %b exp 1", irq); else pass_cnt++;
        chk_cnt++;
        if (st_times.size() - s0 !== 1) $display("FAIL os_pulse_count: got %0d exp 1", st_times.size() - s0);
        else pass_cnt++;
        wr(3'd2, 32'h1);
    endtask

    task automatic test_err();
        logic [31:0] v;
        int s0;
        wr(3'd0, 32'd0);
        s0 = st_times.size();
        wr(3'd1, 32'h1);
        rdw(3'd2, v);
        chk_cnt++;
        if (v !== 32'h4) $display("FAIL err_set: got %0h exp 4", v); else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if (st_times.size() !== s0) $display("FAIL err_no_pulse: got %0d exp %0d", st_times.size(), s0);
        else pass_cnt++;
        wr(3'd2, 32'h4);
        rdw(3'd2, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL err_clear: got %0h exp 0", v); else pass_cnt++;
        wr(3'd0, 32'd4);
        wr(3'd1, 32'h9);
        rdw(3'd2, v);
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if (v !== 32'h0 || st_times.size() !== s0)
            $display("FAIL start_stop_same: status %0h pulses %0d exp 0 and %0d", v, st_times.size(), s0);
        else pass_cnt++;
    endtask

    task automatic test_auto();
        logic [31:0] v;
        int sz;
        st_times.delete();
        wr(3'd0, 32'd3);
        wr(3'd1, 32'h3);
        wait_pulses(2, 40);
        chk_cnt++;
        if (st_times[1] - st_times[0] !== 5) $display("FAIL auto_period3: got %0d exp 5", st_times[1] - st_times[0]);
        else pass_cnt++;
        wr(3'd0, 32'd6);
        wait_pulses(4, 60);
        chk_cnt++;
        if (st_times[2] - st_times[1] !== 5) $display("FAIL auto_period_old: got %0d exp 5", st_times[2] - st_times[1]);
        else pass_cnt++;
        chk_cnt++;
        if (st_times[3] - st_times[2] !== 8) $display("FAIL auto_period6: got %0d exp 8", st_times[3] - st_times[2]);
        else pass_cnt++;
        wr(3'd1, 32'h8);
        rdw(3'd2, v);
        chk_cnt++;
        if (v[1] !== 1'b0) $display("FAIL auto_stop_busy: got %b exp 0", v[1]); else pass_cnt++;
        chk_cnt++;
        if (v[0] !== 1'b1) $display("FAIL auto_done: got %b exp 1", v[0]); else pass_cnt++;
        sz = st_times.size();
        repeat (12) @(negedge clk);
        #1;
        chk_cnt++;
        if (st_times.size() !== sz) $display("FAIL auto_stopped: got %0d pulses exp %0d", st_times.size(), sz);
        else pass_cnt++;
    endtask

    task automatic test_done_w1c();
        logic [31:0] v;
        st_times.delete();
        wr(3'd0, 32'd3);
        wr(3'd1, 32'h7);
        wait_pulses(1, 20);
        repeat (4) @(negedge clk);
        addr = 3'd2; wd = 32'h1; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wd = '0;
        #1;
        chk_cnt++;
        if (tmr_st !== 1'b1) $display("FAIL w1c_coincide_arm: got %b exp 1", tmr_st); else pass_cnt++;
        rdw(3'd2, v);
        chk_cnt++;
        if (v[0] !== 1'b1) $display("FAIL w1c_set_wins: got %b exp 1", v[0]); else pass_cnt++;
        wr(3'd1, 32'hC);
        #1;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL w1c_irq_before: got %b exp 1", irq); else pass_cnt++;
        wr(3'd2, 32'h1);
        rdw(3'd2, v);
        chk_cnt++;
        if (v[0] !== 1'b0) $display("FAIL w1c_clear: got %b exp 0", v[0]); else pass_cnt++;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL w1c_irq_lag: got %b exp 1", irq); else pass_cnt++;
        @(negedge clk); #1;
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL w1c_irq_drop: got %b exp 0", irq); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        st_times.delete();
        wr(3'd0, 32'd6);
        wr(3'd1, 32'h7);
        wait_pulses(2, 40);
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL rmid_pre_irq: got %b exp 1", irq); else pass_cnt++;
        #1;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (irq !== 1'b0 || tmr_st !== 1'b0 || tmr_k !== 32'h0)
            $display("FAIL rmid_outputs: irq %b st %b k %0h exp 0 0 0", irq, tmr_st, tmr_k);
        else pass_cnt++;
        rdw(3'd2, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL rmid_status: got %0h exp 0", v); else pass_cnt++;
        rdw(3'd1, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL rmid_ctrl: got %0h exp 0", v); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_expcnt();
        logic [31:0] v;
`ifdef TIMER_CTRL_EXPCNT_EN
        wr(3'd4, 32'h0);
        st_times.delete();
        wr(3'd0, 32'd2);
        wr(3'd1, 32'h3);
        wait_pulses(4, 60);
        wr(3'd1, 32'h8);
        rdw(3'd4, v);
        chk_cnt++;
        if (v !== 32'd3) $display("FAIL expcnt_three: got %0d exp 3", v); else pass_cnt++;
        wr(3'd4, 32'h55);
        rdw(3'd4, v);
        chk_cnt++;
        if (v !== 32'd0) $display("FAIL expcnt_clear: got %0d exp 0", v); else pass_cnt++;
`else
        wr(3'd4, 32'h5);
        rdw(3'd4, v);
        chk_cnt++;
        if (v !== 32'd0) $display("FAIL word4_unmapped: got %0h exp 0", v); else pass_cnt++;
`endif
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_oneshot();
        test_err();
        test_auto();
        test_done_w1c();
        test_reset_mid();
        test_expcnt();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
